// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding, write-request type and the xy->address map
// for the plot sink frame buffer.
package vga_pkg;

  localparam logic [7:0]  XMAX     = 8'd160;
  localparam logic [6:0]  YMAX     = 7'd120;
  localparam int          CW       = 3;
  localparam int          FB_DEPTH = 19200;
  localparam int          ADDR_W   = 15;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    SCAN_RD  = 2'd2,
    SCAN_OUT = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     data;
  } wr_req_t;

  // y*160 + x built from shifts: 160 = 128 + 32
  function automatic logic [ADDR_W-1:0] xy_addr(input logic [7:0] x, input logic [6:0] y);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one registered
// read port (1-cycle latency, old data on read-during-write).
module fb_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int DW    = CW,
  parameter int AW    = ADDR_W
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLOCK_50) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_plot_sink.sv
// Plot sink: qualifies plot writes into the frame buffer, runs full-screen
// clear and a raster-order valid/ready readback stream.
module vga_plot_sink
  import vga_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [7:0]    vga_x,
  input  logic [6:0]    vga_y,
  input  logic [CW-1:0] vga_colour,
  input  logic          vga_plot,
  input  logic          clear_start,
  input  logic          scan_start,
  output logic          busy,
  output logic          done,
  output logic          plot_dropped,
  output logic [15:0]   plot_count,
  output logic [7:0]    scan_x,
  output logic [6:0]    scan_y,
  output logic [CW-1:0] scan_colour,
  output logic          scan_valid,
  input  logic          scan_ready,
  output logic          scan_last
);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        sx;
  logic [6:0]        sy;
  logic              in_range;
  logic              accept;
  wr_req_t           wr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  assign in_range = (vga_x < XMAX) && (vga_y < YMAX);
  assign accept   = vga_plot && in_range && (state != CLEAR);

  // Clear owns the write port; plots are rejected while it runs.
  always_comb begin
    wr = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        wr.we   = 1'b1;
        wr.addr = clr_cnt;
        wr.data = '0;
      end else if (accept) begin
        wr.we   = 1'b1;
        wr.addr = xy_addr(vga_x, vga_y);
        wr.data = vga_colour;
      end
    end
  end

  assign rd_en   = (state == SCAN_RD);
  assign rd_addr = xy_addr(sx, sy);

  fb_ram #(
    .DEPTH (FB_DEPTH),
    .DW    (CW),
    .AW    (ADDR_W)
  ) u_fb_ram (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .we       (wr.we),
    .waddr    (wr.addr),
    .wdata    (wr.data),
    .re       (rd_en),
    .raddr    (rd_addr),
    .rdata    (scan_colour)
  );

  assign scan_x = sx;
  assign scan_y = sy;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      sx           <= '0;
      sy           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      plot_dropped <= 1'b0;
      plot_count   <= '0;
      scan_valid   <= 1'b0;
      scan_last    <= 1'b0;
    end else begin
      done         <= 1'b0;
      plot_dropped <= vga_plot && !accept;
      if (accept && plot_count != 16'hFFFF) plot_count <= plot_count + 16'd1;

      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            busy       <= 1'b1;
            clr_cnt    <= '0;
            plot_count <= '0;
          end else if (scan_start) begin
            state <= SCAN_RD;
            busy  <= 1'b1;
            sx    <= '0;
            sy    <= '0;
          end
        end

        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        // RAM read issued this cycle; data lands with the SCAN_OUT beat.
        SCAN_RD: begin
          state      <= SCAN_OUT;
          scan_valid <= 1'b1;
          scan_last  <= (sx == XMAX - 8'd1) && (sy == YMAX - 7'd1);
        end

        SCAN_OUT: begin
          if (scan_ready) begin
            scan_valid <= 1'b0;
            scan_last  <= 1'b0;
            if (scan_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= SCAN_RD;
              if (sx == XMAX - 8'd1) begin
                sx <= '0;
                sy <= sy + 7'd1;
              end else begin
                sx <= sx + 8'd1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_hold: assert property (@(posedge CLOCK_50) disable iff (reset)
    (scan_valid && !scan_ready) |=> (scan_valid && $stable(scan_x) && $stable(scan_y)));
  a_done_idle: assert property (@(posedge CLOCK_50) done |-> !busy);
  a_valid_state: assert property (@(posedge CLOCK_50) scan_valid |-> (state == SCAN_OUT));
`endif

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed bench for vga_plot_sink: reset, clear, plot qualification,
// full and stalled readback scans, mid-scan reset.
module tb_vga_plot_sink;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [2:0]  vga_colour = '0;
  logic        vga_plot = 1'b0;
  logic        clear_start = 1'b0;
  logic        scan_start = 1'b0;
  logic        busy, done, plot_dropped;
  logic [15:0] plot_count;
  logic [7:0]  scan_x;
  logic [6:0]  scan_y;
  logic [2:0]  scan_colour;
  logic        scan_valid;
  logic        scan_ready = 1'b0;
  logic        scan_last;

  int checks = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_plot_sink dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .clear_start (clear_start),
    .scan_start  (scan_start),
    .busy        (busy),
    .done        (done),
    .plot_dropped(plot_dropped),
    .plot_count  (plot_count),
    .scan_x      (scan_x),
    .scan_y      (scan_y),
    .scan_colour (scan_colour),
    .scan_valid  (scan_valid),
    .scan_ready  (scan_ready),
    .scan_last   (scan_last)
  );

  // Frame contents after the test plots: (3,4)=5, (159,119)=2, rest 0.
  function automatic logic [2:0] exp_col(input int idx);
    if (idx == 643)   return 3'd5;
    if (idx == 19199) return 3'd2;
    return 3'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checks++; if ({busy, done, plot_dropped} !== 3'b000)
      begin failures++; $display("FAIL reset_flags: got %b expected 000", {busy, done, plot_dropped}); end
    checks++; if (plot_count !== 16'd0)
      begin failures++; $display("FAIL reset_plot_count: got %0d expected 0", plot_count); end
    checks++; if ({scan_valid, scan_last} !== 2'b00)
      begin failures++; $display("FAIL reset_scan_flags: got %b expected 00", {scan_valid, scan_last}); end
    checks++; if ({scan_x, scan_y, scan_colour} !== 18'd0)
      begin failures++; $display("FAIL reset_scan_data: got x=%0d y=%0d c=%0d expected 0", scan_x, scan_y, scan_colour); end
    reset = 1'b0;
    // one accepted plot so the clear's count zeroing is observable
    vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'd1; vga_plot = 1'b1;
    @(negedge CLOCK_50);
    vga_plot = 1'b0;
    checks++; if (plot_count !== 16'd1)
      begin failures++; $display("FAIL idle_plot_count: got %0d expected 1", plot_count); end
  endtask

  task automatic test_clear_both_starts();
    int busy_cyc = 0, done_cnt = 0, valid_seen = 0, overlap = 0;
    clear_start = 1'b1; scan_start = 1'b1;
    @(negedge CLOCK_50);
    clear_start = 1'b0; scan_start = 1'b0;
    checks++; if (busy !== 1'b1)
      begin failures++; $display("FAIL clear_busy_rise: got %b expected 1", busy); end
    checks++; if (plot_count !== 16'd0)
      begin failures++; $display("FAIL clear_count_zero: got %0d expected 0", plot_count); end
    for (int c = 0; c < 19300; c++) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (done && busy) overlap++;
      if (scan_valid) valid_seen++;
      if (busy && busy_cyc == 5000) begin
        vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'd7; vga_plot = 1'b1;
      end
      if (busy && busy_cyc == 5001) begin
        vga_plot = 1'b0;
        checks++; if (plot_dropped !== 1'b1)
          begin failures++; $display("FAIL clear_plot_dropped: got %b expected 1", plot_dropped); end
      end
      @(negedge CLOCK_50);
    end
    checks++; if (busy_cyc != 19200)
      begin failures++; $display("FAIL clear_busy_cycles: got %0d expected 19200", busy_cyc); end
    checks++; if (done_cnt != 1 || overlap != 0)
      begin failures++; $display("FAIL clear_done: got %0d pulses (%0d with busy) expected 1 (0)", done_cnt, overlap); end
    checks++; if (valid_seen != 0)
      begin failures++; $display("FAIL clear_no_scan: got %0d beats expected 0", valid_seen); end
    checks++; if (plot_count !== 16'd0)
      begin failures++; $display("FAIL clear_plot_count: got %0d expected 0", plot_count); end
  endtask

  task automatic test_plot_range();
    int drops = 0;
    vga_colour = 3'd7; vga_plot = 1'b1;
    vga_x = 8'd160; vga_y = 7'd0;
    @(negedge CLOCK_50); if (plot_dropped) drops++;
    vga_x = 8'd0;   vga_y = 7'd120;
    @(negedge CLOCK_50); if (plot_dropped) drops++;
    vga_x = 8'd255; vga_y = 7'd127;
    @(negedge CLOCK_50); if (plot_dropped) drops++;
    vga_plot = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (drops != 3)
      begin failures++; $display("FAIL range_drops: got %0d expected 3", drops); end
    checks++; if (plot_dropped !== 1'b0 || plot_count !== 16'd0)
      begin failures++; $display("FAIL range_after: got dropped=%b count=%0d expected 0 0", plot_dropped, plot_count); end
    vga_x = 8'd3; vga_y = 7'd4; vga_colour = 3'd5; vga_plot = 1'b1;
    @(negedge CLOCK_50);
    vga_x = 8'd159; vga_y = 7'd119; vga_colour = 3'd2;
    @(negedge CLOCK_50);
    vga_plot = 1'b0;
    checks++; if (plot_dropped !== 1'b0)
      begin failures++; $display("FAIL valid_plot_dropped: got %b expected 0", plot_dropped); end
    @(negedge CLOCK_50);
    checks++; if (plot_count !== 16'd2)
      begin failures++; $display("FAIL valid_plot_count: got %0d expected 2", plot_count); end
  endtask

  task automatic test_full_scan();
    int beats = 0, busy_cyc = 0, done_cnt = 0, pos_err = 0, col_err = 0, last_cnt = 0;
    logic last_ok = 1'b0;
    logic [2:0] c643 = 3'd0;
    logic [7:0] ex;
    logic [6:0] ey;
    scan_ready = 1'b1;
    scan_start = 1'b1;
    @(negedge CLOCK_50);
    scan_start = 1'b0;
    for (int c = 0; c < 38500; c++) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (scan_valid) begin
        ex = 8'(beats % 160); ey = 7'(beats / 160);
        if (scan_x !== ex || scan_y !== ey) pos_err++;
        if (scan_colour !== exp_col(beats)) col_err++;
        if (beats == 643) c643 = scan_colour;
        if (scan_last) begin
          last_cnt++;
          if (beats == 19199 && scan_colour === 3'd2) last_ok = 1'b1;
        end
        beats++;
      end
      @(negedge CLOCK_50);
    end
    checks++; if (beats != 19200)
      begin failures++; $display("FAIL scan_beats: got %0d expected 19200", beats); end
    checks++; if (busy_cyc != 38400)
      begin failures++; $display("FAIL scan_cycles: got %0d expected 38400", busy_cyc); end
    checks++; if (done_cnt != 1)
      begin failures++; $display("FAIL scan_done: got %0d expected 1", done_cnt); end
    checks++; if (pos_err != 0)
      begin failures++; $display("FAIL scan_order: got %0d bad beats expected 0", pos_err); end
    checks++; if (col_err != 0)
      begin failures++; $display("FAIL scan_colours: got %0d bad beats expected 0", col_err); end
    checks++; if (c643 !== 3'd5)
      begin failures++; $display("FAIL scan_beat643: got %0d expected 5", c643); end
    checks++; if (last_cnt != 1 || !last_ok)
      begin failures++; $display("FAIL scan_last: got %0d last beats ok=%b expected 1 ok=1", last_cnt, last_ok); end
  endtask

  task automatic test_stall_and_reset();
    int beats = 0, hold_err = 0, seq_err = 0, col_err = 0, stalls = 0, done_cnt = 0;
    logic prev_hold = 1'b0, wrap_seen = 1'b0, rdy;
    logic [7:0] px, ex;
    logic [6:0] py, ey;
    logic [2:0] pc;
    scan_ready = 1'b0;
    scan_start = 1'b1;
    @(negedge CLOCK_50);
    scan_start = 1'b0;
    for (int c = 1; c < 5000; c++) begin
      if (done) done_cnt++;
      if (prev_hold && (!scan_valid || scan_x !== px || scan_y !== py || scan_colour !== pc)) hold_err++;
      rdy = (c % 4 == 0);
      scan_ready = rdy;
      prev_hold = scan_valid && !rdy;
      if (prev_hold) stalls++;
      px = scan_x; py = scan_y; pc = scan_colour;
      if (scan_valid && rdy) begin
        ex = 8'(beats % 160); ey = 7'(beats / 160);
        if (scan_x !== ex || scan_y !== ey) seq_err++;
        if (scan_colour !== exp_col(beats)) col_err++;
        if (beats == 160 && scan_x == 8'd0 && scan_y == 7'd1) wrap_seen = 1'b1;
        beats++;
      end
      @(negedge CLOCK_50);
    end
    checks++; if (hold_err != 0 || stalls == 0)
      begin failures++; $display("FAIL stall_hold: got %0d unstable of %0d stalls expected 0", hold_err, stalls); end
    checks++; if (seq_err != 0 || beats < 700)
      begin failures++; $display("FAIL stall_sequence: got %0d errors over %0d beats expected 0 over >=700", seq_err, beats); end
    checks++; if (col_err != 0)
      begin failures++; $display("FAIL stall_colours: got %0d bad beats expected 0", col_err); end
    checks++; if (!wrap_seen)
      begin failures++; $display("FAIL stall_wrap: got %b expected 1", wrap_seen); end
    // reset at cycle 5000 of the scan
    scan_ready = 1'b0;
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || scan_valid !== 1'b0 || done !== 1'b0)
      begin failures++; $display("FAIL midreset: got busy=%b valid=%b done=%b expected 000", busy, scan_valid, done); end
    for (int c = 0; c < 5; c++) begin
      if (done) done_cnt++;
      @(negedge CLOCK_50);
    end
    checks++; if (done_cnt != 0)
      begin failures++; $display("FAIL midreset_done: got %0d pulses expected 0", done_cnt); end
  endtask

  task automatic test_rescan();
    int beats = 0, col_err = 0;
    logic [2:0] c643 = 3'd0;
    scan_ready = 1'b1;
    scan_start = 1'b1;
    @(negedge CLOCK_50);
    scan_start = 1'b0;
    for (int c = 0; c < 1400; c++) begin
      if (scan_valid) begin
        if (scan_colour !== exp_col(beats)) col_err++;
        if (beats == 643) c643 = scan_colour;
        beats++;
      end
      @(negedge CLOCK_50);
    end
    checks++; if (beats < 644 || c643 !== 3'd5)
      begin failures++; $display("FAIL rescan_pixel: got beats=%0d c643=%0d expected >=644 5", beats, c643); end
    checks++; if (col_err != 0)
      begin failures++; $display("FAIL rescan_colours: got %0d bad beats expected 0", col_err); end
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear_both_starts();
    test_plot_range();
    test_full_scan();
    test_stall_and_reset();
    test_rescan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
